// File: rtl/debounced_bcd_counter_pkg.sv
// Shared constants for the debounced BCD counter: digit width, BCD limits,
// step encoding and the default debounce length.
package debounced_bcd_counter_pkg;

  localparam int              BCD_W         = 4;
  localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
  localparam int              DB_CYCLES_DEF = 1_000_000;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_UP   = 2'd1;
  localparam logic [1:0] STEP_DN   = 2'd2;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
    return (d == '0) ? BCD_MAX : d - 1'b1;
  endfunction

endpackage

// File: rtl/debounced_bcd_counter_button_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter, rising-edge step pulse.
// Auto-repeat while held is built only when DCNT_AUTOREPEAT_EN is defined.
module button_debounce
  import debounced_bcd_counter_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;
  logic          rep;

  // Any cycle where the synced level agrees with the debounced state restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) db_d  = ~db_q;
      else                             cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef DCNT_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);

  logic [HW-1:0] hold_q, hold_d;

  // Reloading to DELAY-RATE+1 after each repeat makes later repeats RATE cycles apart.
  assign rep = db_q && (hold_q == HW'(REPEAT_DELAY));

  always_comb begin
    hold_d = '0;
    if (db_q) hold_d = rep ? HW'(REPEAT_DELAY - REPEAT_RATE + 1) : hold_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      pulse_q   <= (db_q & ~db_prev_q) | rep;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/debounced_bcd_counter.sv
// Debounced up/down buttons driving an NDIG-digit BCD counter with wrap flag.
// Optional auto-repeat inside the button stages: DCNT_AUTOREPEAT_EN.
module debounced_bcd_counter
  import debounced_bcd_counter_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int NDIG         = 8,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_dn,
  input  logic                  clr,
  output logic [BCD_W*NDIG-1:0] count_bcd,
  output logic                  up_pulse,
  output logic                  dn_pulse,
  output logic                  wrap
);

  logic                        up_p, dn_p;
  logic [1:0]                  step;
  logic                        go_up, go_dn;
  logic [NDIG-1:0]             is9, is0;
  logic [NDIG-1:0][BCD_W-1:0]  cnt_q, cnt_d;
  logic                        wrap_q, wrap_d;

  button_debounce #(
    .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_db_up (.clk(clk), .reset(reset), .btn_i(btn_up), .pulse_o(up_p));

  button_debounce #(
    .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_db_dn (.clk(clk), .reset(reset), .btn_i(btn_dn), .pulse_o(dn_p));

  // Simultaneous up and down cancel out.
  always_comb begin
    step = STEP_NONE;
    if (up_p && !dn_p)      step = STEP_UP;
    else if (dn_p && !up_p) step = STEP_DN;
  end

  assign go_up = (step == STEP_UP);
  assign go_dn = (step == STEP_DN);

  // Carry/borrow into a digit is the AND of the lower digits being 9 (up) or 0 (down).
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic cin;
    assign is9[g] = (cnt_q[g] == BCD_MAX);
    assign is0[g] = (cnt_q[g] == '0);
    if (g == 0) begin : g_lsd
      assign cin = go_up | go_dn;
    end else begin : g_upper
      assign cin = go_up ? (&is9[g-1:0]) : (go_dn & (&is0[g-1:0]));
    end
    assign cnt_d[g] = !cin ? cnt_q[g] : (go_up ? bcd_inc(cnt_q[g]) : bcd_dec(cnt_q[g]));
  end

  assign wrap_d = go_up ? (&is9) : (go_dn & (&is0));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign count_bcd = cnt_q;
  assign up_pulse  = up_p;
  assign dn_pulse  = dn_p;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_debounced_bcd_counter.sv
// Directed bench for debounced_bcd_counter (DB_CYCLES=4, NDIG=8, REPEAT 20/5).
module tb_debounced_bcd_counter;

  localparam int NDIG = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            btn_up = 1'b0;
  logic            btn_dn = 1'b0;
  logic            clr = 1'b0;
  logic [4*NDIG-1:0] count_bcd;
  logic            up_pulse, dn_pulse, wrap;

  int checks = 0;
  int errors = 0;
  int nu, nd, nw;
  logic [5:0] bounce;

  always #5 clk = ~clk;

  debounced_bcd_counter #(
    .DB_CYCLES(4), .NDIG(NDIG), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
    .count_bcd(count_bcd), .up_pulse(up_pulse), .dn_pulse(dn_pulse), .wrap(wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample_counts();
    if (up_pulse === 1'b1) nu++;
    if (dn_pulse === 1'b1) nd++;
    if (wrap === 1'b1)     nw++;
  endtask

  // Hold the buttons 8 cycles (pulse at +7, count at +8), then release and settle.
  task automatic press(input logic u, input logic d);
    nu = 0; nd = 0; nw = 0;
    btn_up = u; btn_dn = d;
    repeat (8) begin tick(); sample_counts(); end
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (10) begin tick(); sample_counts(); end
  endtask

  initial begin
    // 1: reset held with btn_up high, then release
    btn_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_outputs", {count_bcd[27:0], up_pulse, dn_pulse, wrap, 1'b0},
          32'h0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 7) chk("first_pulse_timing", {31'b0, up_pulse}, {31'b0, k == 7});
    end
    chk("count_after_first", count_bcd, 32'h00000001);
    nu = 0; nd = 0; nw = 0;
    btn_up = 1'b0;
    repeat (10) begin tick(); sample_counts(); end
    chk("release_no_step", nu, 0);

    // 2: glitch rejected, bouncing press gives one step
    nu = 0; nd = 0; nw = 0;
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    repeat (10) begin tick(); sample_counts(); end
    chk("glitch_pulses", nu, 0);
    chk("glitch_count", count_bcd, 32'h00000001);
    bounce = 6'b111101;
    nu = 0; nd = 0; nw = 0;
    for (int i = 0; i < 6; i++) begin btn_up = bounce[i]; tick(); sample_counts(); end
    repeat (8) begin tick(); sample_counts(); end
    btn_up = 1'b0;
    repeat (10) begin tick(); sample_counts(); end
    chk("bounce_pulses", nu, 1);
    chk("bounce_count", count_bcd, 32'h00000002);

    // 3: decimal carry, then borrow wrap from zero
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0);
    chk("count_nine", count_bcd, 32'h00000009);
    press(1'b1, 1'b0);
    chk("carry_count", count_bcd, 32'h00000010);
    chk("carry_no_wrap", nw, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_count", count_bcd, 32'h00000000);
    press(1'b0, 1'b1);
    chk("dn_wrap_count", count_bcd, 32'h99999999);
    chk("dn_wrap_flag", nw, 1);
    chk("dn_pulse_count", nd, 1);

    // 4: all-9s wraps up to zero; simultaneous press is a no-op
    press(1'b1, 1'b0);
    chk("up_wrap_count", count_bcd, 32'h00000000);
    chk("up_wrap_flag", nw, 1);
    press(1'b1, 1'b1);
    chk("both_up_pulse", nu, 1);
    chk("both_dn_pulse", nd, 1);
    chk("both_count", count_bcd, 32'h00000000);
    chk("both_wrap", nw, 0);

    // 5: clr coincides with an up pulse that would otherwise wrap
    press(1'b0, 1'b1);
    chk("pre_clr_count", count_bcd, 32'h99999999);
    btn_up = 1'b1;
    repeat (7) tick();
    clr = 1'b1;
    chk("clr_up_pulse", {31'b0, up_pulse}, 32'h1);
    tick();
    clr = 1'b0;
    chk("clr_wins_count", count_bcd, 32'h00000000);
    chk("clr_wins_wrap", {31'b0, wrap}, 32'h0);
    btn_up = 1'b0;
    repeat (10) tick();

    // 6: long hold
    btn_up = 1'b1;
    repeat (7) tick();
    chk("hold_first_pulse", {31'b0, up_pulse}, 32'h1);
    nu = 0; nd = 0; nw = 0;
    for (int k = 1; k <= 60; k++) begin tick(); sample_counts(); end
    btn_up = 1'b0;
`ifdef DCNT_AUTOREPEAT_EN
    chk("hold_repeat_pulses", nu, 9);
    repeat (12) tick();
`else
    chk("hold_repeat_pulses", nu, 0);
    repeat (12) tick();
    chk("hold_count", count_bcd, 32'h00000001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
